// File: rtl/key_encoder.sv
// Piano key front end: debounces keys and buttons, tracks the octave and
// encodes the accepted key as {octave, mode, degree} with a latch strobe.
module key_encoder #(
  parameter logic [19:0] DEBOUNCE   = 20'd1000000,
  parameter logic [7:0]  STROBE_LEN = 8'd4,
  parameter logic [2:0]  OCT_INIT   = 3'd4
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [6:0] iKey,
  input  logic       iSharp,
  input  logic       iOctUp,
  input  logic       iOctDown,
  output logic [7:0] oData,
  output logic       oState,
  output logic       oPressed,
  output logic [2:0] oOctave
);

  localparam int NIN     = 10;
  localparam int I_SHARP = 7;
  localparam int I_UP    = 8;
  localparam int I_DOWN  = 9;

  localparam logic [19:0] DB_RELOAD = DEBOUNCE - 20'd1;
  localparam logic [7:0]  ST_RELOAD = STROBE_LEN - 8'd1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STROBE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync1;
  logic [NIN-1:0] sync2;
  logic [NIN-1:0] deb;
  logic [NIN-1:0] deb_nxt;
  logic [19:0]    db_cnt [NIN];

  logic [6:0] key_rise;
  logic       up_rise;
  logic       down_rise;
  logic [2:0] pick;

  logic [1:0] state;
  logic [7:0] strobe_cnt;
  logic [2:0] sel;

  assign raw = {iOctDown, iOctUp, iSharp, iKey};

  function automatic logic [2:0] lowest(input logic [6:0] v);
    lowest = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (v[i]) lowest = 3'(i);
    end
  endfunction

  // Next debounced value, used as the edge reference so an accepted edge
  // acts on the same clock edge that the debouncer commits it.
  always_comb begin
    deb_nxt = deb;
    for (int i = 0; i < NIN; i++) begin
      if ((sync2[i] != deb[i]) && (db_cnt[i] == 20'd0)) deb_nxt[i] = sync2[i];
    end
  end

  assign key_rise  = deb_nxt[6:0] & ~deb[6:0];
  assign up_rise   = deb_nxt[I_UP] & ~deb[I_UP];
  assign down_rise = deb_nxt[I_DOWN] & ~deb[I_DOWN];
  assign pick      = lowest(key_rise);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < NIN; i++) db_cnt[i] <= 20'd0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb   <= deb_nxt;
      for (int i = 0; i < NIN; i++) begin
        if ((sync2[i] == deb[i]) || (db_cnt[i] == 20'd0)) db_cnt[i] <= DB_RELOAD;
        else                                              db_cnt[i] <= db_cnt[i] - 20'd1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oOctave <= OCT_INIT;
    end else if (up_rise && !down_rise && (oOctave != 3'd7)) begin
      oOctave <= oOctave + 3'd1;
    end else if (down_rise && !up_rise && (oOctave != 3'd0)) begin
      oOctave <= oOctave - 3'd1;
    end
  end

  // Strobe protocol: oData is loaded on the rising edge of oState and held
  // for STROBE_LEN cycles; the consumer latches it on the falling edge.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= IDLE;
      oData      <= {OCT_INIT, 5'd0};
      oState     <= 1'b0;
      oPressed   <= 1'b0;
      strobe_cnt <= 8'd0;
      sel        <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|key_rise) begin
            state      <= STROBE;
            sel        <= pick;
            oData      <= {oOctave, (deb_nxt[I_SHARP] ? 2'b01 : 2'b00), pick + 3'd1};
            oState     <= 1'b1;
            oPressed   <= 1'b1;
            strobe_cnt <= ST_RELOAD;
          end
        end
        STROBE: begin
          if (strobe_cnt == 8'd0) begin
            state  <= HOLD;
            oState <= 1'b0;
          end else begin
            strobe_cnt <= strobe_cnt - 8'd1;
          end
        end
        HOLD: begin
          if (!deb_nxt[sel]) begin
            state    <= IDLE;
            oPressed <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          oState   <= 1'b0;
          oPressed <= 1'b0;
        end
      endcase
    end
  end

endmodule
